// File: rtl/edge_row_fetcher_pkg.sv
// Shared defaults, FSM state type and address-stride helper for the adjacency-row fetcher.
package edge_row_fetcher_pkg;

  localparam int DEFAULT_MADDR_WIDTH = 16;
  localparam int DEFAULT_MDATA_WIDTH = 32;
  localparam int DEFAULT_MAX_NODES   = 16;
  localparam int DEFAULT_INDEX_WIDTH = 8;
  localparam int DEFAULT_VALUE_WIDTH = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT,
    S_RELEASE,
    S_EMIT,
    S_FINISH
  } fetch_state_e;

  // Matrix elements are one address-width word apart, addressed in bytes.
  function automatic int word_stride(input int maddr_width);
    return maddr_width / 8;
  endfunction

endpackage

// File: rtl/edge_row_fetcher_addr_gen.sv
// Row start address (base + row*n*stride) and per-column stride increment, modulo 2^MADDR_WIDTH.
module edge_addr_gen
  import edge_row_fetcher_pkg::*;
#(
  parameter int MADDR_WIDTH = DEFAULT_MADDR_WIDTH,
  parameter int INDEX_WIDTH = DEFAULT_INDEX_WIDTH
) (
  input  logic [MADDR_WIDTH-1:0] base_address,
  input  logic [INDEX_WIDTH-1:0] row,
  input  logic [INDEX_WIDTH-1:0] number_of_nodes,
  input  logic [MADDR_WIDTH-1:0] cur_addr,
  output logic [MADDR_WIDTH-1:0] start_addr,
  output logic [MADDR_WIDTH-1:0] next_addr
);

  localparam logic [MADDR_WIDTH-1:0] STRIDE = MADDR_WIDTH'(word_stride(MADDR_WIDTH));

  logic [MADDR_WIDTH-1:0] row_offset;

  // Truncating each factor first is exact because the result is only needed modulo 2^MADDR_WIDTH.
  assign row_offset = MADDR_WIDTH'(row) * MADDR_WIDTH'(number_of_nodes) * STRIDE;
  assign start_addr = base_address + row_offset;
  assign next_addr  = cur_addr + STRIDE;

endmodule

// File: rtl/edge_row_fetcher.sv
// Bus-master reader: fetches one adjacency-matrix row over the shared tri-state bus and
// streams (column, weight) pairs to the relaxation logic under valid/ready.
module edge_row_fetcher
  import edge_row_fetcher_pkg::*;
#(
  parameter int MADDR_WIDTH = DEFAULT_MADDR_WIDTH,
  parameter int MDATA_WIDTH = DEFAULT_MDATA_WIDTH,
  parameter int MAX_NODES   = DEFAULT_MAX_NODES,
  parameter int INDEX_WIDTH = DEFAULT_INDEX_WIDTH,
  parameter int VALUE_WIDTH = DEFAULT_VALUE_WIDTH
) (
  input  logic                   reset,
  input  logic                   clock,
  input  logic                   start,
  input  logic [INDEX_WIDTH-1:0] row,
  input  logic [INDEX_WIDTH-1:0] number_of_nodes,
  input  logic [MADDR_WIDTH-1:0] base_address,
  output wire                    mem_read_enable,
  output wire  [MADDR_WIDTH-1:0] mem_addr,
  input  logic                   mem_read_ready,
  input  logic [MDATA_WIDTH-1:0] mem_read_data,
  output logic                   edge_valid,
  input  logic                   edge_ready,
  output logic [INDEX_WIDTH-1:0] edge_column,
  output logic [VALUE_WIDTH-1:0] edge_weight,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);

  // MAX_NODES only documents the sizing of INDEX_WIDTH; the datapath never needs it.
  localparam int unused_max_nodes = MAX_NODES;

  fetch_state_e           state_q, state_d;
  logic [MADDR_WIDTH-1:0] addr_q, addr_d;
  logic [INDEX_WIDTH-1:0] column_q, column_d;
  logic [INDEX_WIDTH-1:0] n_q, n_d;
  logic [VALUE_WIDTH-1:0] weight_q, weight_d;
  logic                   error_q, error_d;

  logic [MADDR_WIDTH-1:0] start_addr, next_addr;
  logic                   nothing_to_fetch;
  logic                   own_bus;
  logic                   unused_data_bits;

  edge_addr_gen #(
    .MADDR_WIDTH (MADDR_WIDTH),
    .INDEX_WIDTH (INDEX_WIDTH)
  ) u_addr_gen (
    .base_address    (base_address),
    .row             (row),
    .number_of_nodes (number_of_nodes),
    .cur_addr        (addr_q),
    .start_addr      (start_addr),
    .next_addr       (next_addr)
  );

  assign nothing_to_fetch = (number_of_nodes == '0) || (row >= number_of_nodes);
  assign unused_data_bits = ^mem_read_data[MDATA_WIDTH-1:VALUE_WIDTH];

  always_comb begin
    // NOTE: every always_comb output is defaulted first so no branch can leave a latch behind.
    state_d  = state_q;
    addr_d   = addr_q;
    column_d = column_q;
    n_d      = n_q;
    weight_d = weight_q;
    error_d  = error_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d      = number_of_nodes;
          addr_d   = start_addr;
          column_d = '0;
          error_d  = (number_of_nodes != '0) && (row >= number_of_nodes);
          state_d  = nothing_to_fetch ? S_FINISH : S_ADDR;
        end
      end
      S_ADDR:    state_d = S_WAIT;
      S_WAIT: begin
        if (mem_read_ready) begin
          weight_d = mem_read_data[VALUE_WIDTH-1:0];
          state_d  = S_RELEASE;
        end
      end
      // One idle bus cycle gives the memory time to drop mem_read_ready.
      S_RELEASE: state_d = S_EMIT;
      S_EMIT: begin
        if (edge_ready) begin
          if (column_q == n_q - INDEX_WIDTH'(1)) begin
            state_d = S_FINISH;
          end else begin
            column_d = column_q + INDEX_WIDTH'(1);
            addr_d   = next_addr;
            state_d  = S_ADDR;
          end
        end
      end
      S_FINISH:  state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      column_q <= '0;
      n_q      <= '0;
      weight_q <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      column_q <= column_d;
      n_q      <= n_d;
      weight_q <= weight_d;
      error_q  <= error_d;
    end
  end

  // Bus ownership is decoded straight from the state flop, so reset releases the bus at once.
  assign own_bus         = (state_q == S_ADDR) || (state_q == S_WAIT);
  assign mem_read_enable = own_bus ? 1'b1 : 1'bz;
  assign mem_addr        = own_bus ? addr_q : {MADDR_WIDTH{1'bz}};

  assign edge_valid  = (state_q == S_EMIT);
  assign edge_column = column_q;
  assign edge_weight = weight_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_FINISH);
  assign error       = done && error_q;

endmodule

// File: tb/tb_edge_row_fetcher.sv
// Randomized scoreboard bench for edge_row_fetcher: behavioural memory on the tri-state bus,
// expected edges/done pushed at start, popped by an independent monitor.
module tb_edge_row_fetcher;
  import edge_row_fetcher_pkg::*;

  localparam int AW        = DEFAULT_MADDR_WIDTH;
  localparam int DW        = DEFAULT_MDATA_WIDTH;
  localparam int IW        = DEFAULT_INDEX_WIDTH;
  localparam int VW        = DEFAULT_VALUE_WIDTH;
  localparam int NMAX      = DEFAULT_MAX_NODES;
  localparam int STRIDE    = AW / 8;
  localparam int MEM_WORDS = 1 << AW;

  typedef struct {
    int col;
    int w;
  } edge_exp_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [IW-1:0] row = '0;
  logic [IW-1:0] number_of_nodes = '0;
  logic [AW-1:0] base_address = '0;
  wire           mem_read_enable;
  wire  [AW-1:0] mem_addr;
  logic          mem_read_ready = 1'b0;
  logic [DW-1:0] mem_read_data = '0;
  logic          edge_valid;
  logic          edge_ready = 1'b1;
  logic [IW-1:0] edge_column;
  logic [VW-1:0] edge_weight;
  logic          busy, done, error;

  int checks = 0;
  int failures = 0;
  edge_exp_t edge_q[$];
  logic      done_q[$];
  int ready_mode = 0;
  int lat_min = 0, lat_max = 0, lat_cnt = 0;
  int reads_issued = 0, accepts = 0, vcnt = 0;
  logic          prev_en = 1'b0;
  logic          hold_valid = 1'b0;
  logic [IW-1:0] hold_col = '0;
  logic [VW-1:0] hold_w = '0;
  logic [DW-1:0] mem [MEM_WORDS];

  edge_row_fetcher dut (
    .reset           (reset),
    .clock           (clock),
    .start           (start),
    .row             (row),
    .number_of_nodes (number_of_nodes),
    .base_address    (base_address),
    .mem_read_enable (mem_read_enable),
    .mem_addr        (mem_addr),
    .mem_read_ready  (mem_read_ready),
    .mem_read_data   (mem_read_data),
    .edge_valid      (edge_valid),
    .edge_ready      (edge_ready),
    .edge_column     (edge_column),
    .edge_weight     (edge_weight),
    .busy            (busy),
    .done            (done),
    .error           (error)
  );

  // A released enable line reads back as 0, so a 1 here means the fetcher is driving the bus.
  pulldown pd_en (mem_read_enable);

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic fail_event(input string name, input string what);
    checks++;
    failures++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Byte-addressed memory: a read request answers after a random number of bus cycles.
  always @(negedge clock) begin
    if (mem_read_enable === 1'b1) begin
      if (!prev_en) reads_issued++;
      if (lat_cnt == 0) begin
        mem_read_ready = 1'b1;
        mem_read_data  = mem[mem_addr];
      end else begin
        lat_cnt--;
      end
      prev_en = 1'b1;
    end else begin
      mem_read_ready = 1'b0;
      lat_cnt        = $urandom_range(lat_max, lat_min);
      prev_en        = 1'b0;
    end
  end

  // Consumer: always ready, 5 stalled cycles per edge, or random.
  always @(posedge clock) begin
    #1;
    if (!edge_valid) vcnt = 0;
    case (ready_mode)
      0: edge_ready = 1'b1;
      1: begin
        edge_ready = edge_valid && (vcnt >= 5);
        if (edge_valid) vcnt++;
      end
      default: edge_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: holds stability while stalled, pops the scoreboard on every accept and done.
  always @(negedge clock) begin
    if (reset) begin
      hold_valid = 1'b0;
    end else begin
      if (hold_valid) begin
        check("stall_valid_held", edge_valid, 1'b1);
        check("stall_column_held", edge_column, hold_col);
        check("stall_weight_held", edge_weight, hold_w);
      end
      if (edge_valid && edge_ready) begin
        accepts++;
        if (edge_q.size() == 0) begin
          fail_event("unexpected_edge", $sformatf("column=%0d weight=0x%0h", edge_column, edge_weight));
        end else begin
          edge_exp_t e;
          e = edge_q.pop_front();
          check("edge_column", edge_column, e.col);
          check("edge_weight", edge_weight, e.w);
        end
      end
      hold_valid = edge_valid && !edge_ready;
      hold_col   = edge_column;
      hold_w     = edge_weight;
      if (done) begin
        if (done_q.size() == 0) fail_event("unexpected_done", $sformatf("error=%0b", error));
        else check("done_error", error, done_q.pop_front());
      end
    end
  end

  function automatic void push_expected(input int r, input int n, input int b);
    if (n == 0 || r >= n) begin
      done_q.push_back(n != 0);
    end else begin
      for (int c = 0; c < n; c++) begin
        int unsigned a;
        a = (b + (r * n + c) * STRIDE) % MEM_WORDS;
        edge_q.push_back('{c, int'(mem[a][VW-1:0])});
      end
      done_q.push_back(1'b0);
    end
  endfunction

  task automatic recover();
    reset = 1'b1;
    @(posedge clock); #1;
    edge_q.delete();
    done_q.delete();
    reset = 1'b0;
  endtask

  task automatic run_fetch(input int r, input int n, input int b, input int exp_cycles);
    int r0, cyc;
    r0  = reads_issued;
    cyc = 0;
    push_expected(r, n, b);
    row             = IW'(r);
    number_of_nodes = IW'(n);
    base_address    = AW'(b);
    start           = 1'b1;
    @(posedge clock); #1;
    start           = 1'b0;
    row             = IW'($urandom);
    number_of_nodes = IW'($urandom);
    base_address    = AW'($urandom);
    while (!done && cyc < 4000) begin
      @(posedge clock); #1;
      cyc++;
      start = (cyc == 2) && busy && !done;
    end
    start = 1'b0;
    if (!done) begin
      fail_event("done_timeout", $sformatf("row=%0d n=%0d no done within %0d cycles", r, n, cyc));
      recover();
    end else begin
      if (exp_cycles >= 0) check("cycles_to_done", cyc, exp_cycles);
      @(posedge clock); #1;
      check("done_one_cycle", done, 1'b0);
      check("idle_after_done", busy, 1'b0);
      check("reads_issued", reads_issued - r0, (n == 0 || r >= n) ? 0 : n);
      check("edges_all_seen", edge_q.size(), 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a0, cyc;
    for (int a = 0; a < MEM_WORDS; a++) mem[a] = $urandom;
    repeat (3) @(posedge clock);
    #1;
    check("reset_busy", busy, 1'b0);
    check("reset_edge_valid", edge_valid, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_error", error, 1'b0);
    check("reset_column", edge_column, '0);
    check("reset_weight", edge_weight, '0);
    check("reset_bus_released", mem_read_enable, 1'b0);
    reset = 1'b0;
    @(posedge clock); #1;

    // Full row, zero memory latency, consumer always ready: 4 cycles per edge.
    ready_mode = 0; lat_min = 0; lat_max = 0;
    run_fetch(3, 8, 0, 32);

    // Stalled consumer with variable memory latency.
    ready_mode = 1; lat_max = 3;
    run_fetch(0, 8, 0, -1);

    // Empty graph and out-of-range row complete without touching the bus.
    ready_mode = 0;
    run_fetch(0, 0, 0, 0);
    run_fetch(8, 8, 0, 0);

    // Row starting two words below the top of the address space wraps to 0.
    run_fetch(0, 8, MEM_WORDS - 2 * STRIDE, -1);

    // Reset while waiting on the read for column 4.
    lat_min = 30; lat_max = 30;
    a0 = accepts; cyc = 0;
    push_expected(2, 8, 'h100);
    row = IW'(2); number_of_nodes = IW'(8); base_address = AW'('h100); start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    while (!((accepts - a0) >= 4 && mem_read_enable === 1'b1) && cyc < 500) begin
      @(posedge clock); #1;
      cyc++;
    end
    if (cyc >= 500) begin
      fail_event("reach_column4_timeout", "column 4 read never issued");
      recover();
    end else begin
      @(posedge clock); #1;
      check("wait_column", edge_column, 4);
      check("wait_bus_owned", mem_read_enable, 1'b1);
      reset = 1'b1;
      #1;
      check("midreset_bus_released", mem_read_enable, 1'b0);
      check("midreset_edge_valid", edge_valid, 1'b0);
      check("midreset_busy", busy, 1'b0);
      check("midreset_done", done, 1'b0);
      edge_q.delete();
      done_q.delete();
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      repeat (5) @(posedge clock);
      #1;
      check("postreset_column", edge_column, '0);
      check("postreset_busy", busy, 1'b0);
    end

    // Randomized rows, sizes, bases, memory latency and consumer behaviour.
    lat_min = 0;
    for (int t = 0; t < 24; t++) begin
      int n, r;
      n          = $urandom_range(0, NMAX);
      r          = $urandom_range(0, n + 1);
      ready_mode = $urandom_range(0, 2);
      lat_max    = $urandom_range(0, 3);
      run_fetch(r, n, int'($urandom_range(0, MEM_WORDS - 1)), -1);
    end

    repeat (4) @(posedge clock);
    #1;
    check("final_edge_queue_empty", edge_q.size(), 0);
    check("final_done_queue_empty", done_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
